// File: rtl/align_ctrl_if.sv
// Stream and aligner signal bundle for align_ctrl.
// master = producers + aligner side, slave = the sequencer.
interface align_ctrl_if #(
    parameter int DW = 32
);
    logic [DW-1:0] a_data;
    logic          a_valid;
    logic          a_ready;
    logic [DW-1:0] b_data;
    logic          b_valid;
    logic          b_ready;
    logic [DW-1:0] x_i1;
    logic [DW-1:0] x_i2;
    logic          write;
    logic          al_dv;
    logic          al_done;

    modport master (
        output a_data, a_valid, b_data, b_valid, al_dv, al_done,
        input  a_ready, b_ready, x_i1, x_i2, write
    );

    modport slave (
        input  a_data, a_valid, b_data, b_valid, al_dv, al_done,
        output a_ready, b_ready, x_i1, x_i2, write
    );
endinterface

// File: rtl/align_ctrl.sv
// Two-stream align buffer sequencer: pairs A/B words into aligner writes, frames and drain checks.
// Optional watchdog on WAIT/DRAIN enabled by defining ALIGN_CTRL_TIMEOUT_EN.
module align_ctrl #(
    parameter int ROMSIZE = 2,
    parameter int DW      = 32,
    parameter int FW      = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [FW-1:0] nframes,
    align_ctrl_if.slave   bus,
    output logic          busy,
    output logic [FW-1:0] frame_cnt,
    output logic          sess_done,
    output logic          err
);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, DRAIN} state_t;

    localparam logic [4:0] LAST_PAIR = 5'(ROMSIZE - 1);
    localparam logic [5:0] BURST_LEN = 6'(2 * ROMSIZE);

    state_t        state;
    logic [FW-1:0] nframes_q;
    logic [4:0]    pair_cnt;
    logic [5:0]    burst_cnt;
    logic [DW-1:0] x1_q;
    logic [DW-1:0] x2_q;
    logic          write_q;
    logic          xfer;
    logic [FW-1:0] frame_nxt;

    // A stream is only offered ready when its partner can complete the pair.
    assign bus.a_ready = (state == LOAD) && bus.b_valid;
    assign bus.b_ready = (state == LOAD) && bus.a_valid;
    assign xfer        = (state == LOAD) && bus.a_valid && bus.b_valid;
    assign frame_nxt   = frame_cnt + FW'(1);

    assign bus.x_i1  = x1_q;
    assign bus.x_i2  = x2_q;
    assign bus.write = write_q;

`ifdef ALIGN_CTRL_TIMEOUT_EN
    logic [15:0] wd;
    logic        wd_hold;

    // True while the FSM will stay in WAIT/DRAIN this cycle.
    assign wd_hold = ((state == WAIT)  && !bus.al_done) ||
                     ((state == DRAIN) &&  bus.al_done);
`endif

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            nframes_q <= '0;
            pair_cnt  <= '0;
            burst_cnt <= '0;
            x1_q      <= '0;
            x2_q      <= '0;
            write_q   <= 1'b0;
            busy      <= 1'b0;
            frame_cnt <= '0;
            sess_done <= 1'b0;
            err       <= 1'b0;
`ifdef ALIGN_CTRL_TIMEOUT_EN
            wd        <= '0;
`endif
        end else begin
            // NOTE: strobes default low each cycle so any branch that raises them yields a one-cycle pulse.
            write_q   <= 1'b0;
            sess_done <= 1'b0;

            case (state)
                IDLE: begin
                    if (start && (nframes != '0)) begin
                        nframes_q <= nframes;
                        frame_cnt <= '0;
                        pair_cnt  <= '0;
                        burst_cnt <= '0;
                        err       <= 1'b0;
                        busy      <= 1'b1;
                        state     <= LOAD;
                    end
                end

                LOAD: begin
                    if (xfer) begin
                        x1_q    <= bus.a_data;
                        x2_q    <= bus.b_data;
                        write_q <= 1'b1;
                        if (pair_cnt == LAST_PAIR) begin
                            pair_cnt <= '0;
                            state    <= WAIT;
                        end else begin
                            pair_cnt <= pair_cnt + 5'd1;
                        end
                    end
                end

                WAIT: begin
                    if (bus.al_done) state <= DRAIN;
                end

                DRAIN: begin
                    if (!bus.al_done) begin
                        if (burst_cnt != BURST_LEN) err <= 1'b1;
                        burst_cnt <= '0;
                        frame_cnt <= frame_nxt;
                        if (frame_nxt == nframes_q) begin
                            sess_done <= 1'b1;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            state <= LOAD;
                        end
                    end else if (bus.al_dv) begin
                        burst_cnt <= burst_cnt + 6'd1;
                    end
                end

                default: state <= IDLE;
            endcase

`ifdef ALIGN_CTRL_TIMEOUT_EN
            // Watchdog overrides the case above when the aligner never finishes.
            if (wd_hold) begin
                if (wd == 16'hFFFF) begin
                    wd        <= '0;
                    err       <= 1'b1;
                    sess_done <= 1'b1;
                    busy      <= 1'b0;
                    pair_cnt  <= '0;
                    burst_cnt <= '0;
                    state     <= IDLE;
                end else begin
                    wd <= wd + 16'd1;
                end
            end else begin
                wd <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_align_ctrl.sv
// Self-checking bench for align_ctrl: random producers, a behavioural aligner and a pair scoreboard.
module tb_align_ctrl;
    localparam int R  = 2;
    localparam int DW = 32;
    localparam int FW = 16;

    logic          clk     = 1'b0;
    logic          rst     = 1'b0;
    logic          start   = 1'b0;
    logic [FW-1:0] nframes = '0;
    logic          busy;
    logic [FW-1:0] frame_cnt;
    logic          sess_done;
    logic          err;

    align_ctrl_if #(.DW(DW)) bus ();

    align_ctrl #(.ROMSIZE(R), .DW(DW), .FW(FW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .nframes   (nframes),
        .bus       (bus),
        .busy      (busy),
        .frame_cnt (frame_cnt),
        .sess_done (sess_done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Producer / scoreboard / aligner model state
    int            mode;
    logic [DW-1:0] a_base, b_base;
    int            a_idx, b_idx;
    bit            b_tog;
    logic [DW-1:0] exp_a[$], exp_b[$];
    logic [DW-1:0] al_a[$], al_b[$];
    logic [DW-1:0] emitted[$];
    int            al_t = -1;
    int            al_wr, frame_no, xfer_in_frame;
    int            short_frame = -1;
    bit            hang, frozen, active, done_fell;
    int            writes_seen = 0;
    int            sess_pulses = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        exp_a.delete(); exp_b.delete();
        al_a.delete();  al_b.delete();
        emitted.delete();
        al_t = -1; al_wr = 0; frame_no = 0; xfer_in_frame = 0;
        a_idx = 0; b_idx = 0;
        frozen = 0; active = 0;
    endtask

    // One clock: observe registered outputs after the edge, update models, drive inputs,
    // then check the combinational handshake mid-cycle.
    task automatic step();
        int  n;
        int  k;
        bit  av, bv, xfer;
        @(posedge clk);
        #1;
        done_fell = 0;
        n = (frame_no == short_frame) ? 2*R - 1 : 2*R;
        if (al_t >= 0) al_t++;
        bus.al_done = !hang && (al_t >= 2) && (al_t <= 2 + n);
        bus.al_dv   = !hang && (al_t >= 3) && (al_t <= 2 + n);
        if (bus.al_dv) begin
            k = al_t - 3;
            emitted.push_back(k < R ? al_a[k] : al_b[k-R]);
        end
        if (!hang && al_t == 3 + n) begin
            al_t = -1;
            al_a.delete(); al_b.delete();
            frame_no++;
            done_fell = 1;
        end

        if (sess_done) begin
            sess_pulses++;
            active = 0;
        end
        check("busy", busy, active);

        if (bus.write) begin
            writes_seen++;
            check("wr_during_done", bus.al_done, 0);
            check("wr_pending", exp_a.size(), 1);
            if (exp_a.size() > 0) begin
                check("x_i1", bus.x_i1, exp_a.pop_front());
                check("x_i2", bus.x_i2, exp_b.pop_front());
            end
            al_a.push_back(bus.x_i1);
            al_b.push_back(bus.x_i2);
            al_wr++;
            if (al_wr == R) begin
                al_wr = 0;
                al_t  = 0;
            end
        end

        case (mode)
            0: begin av = 1; bv = 1; end
            1: begin av = 1; b_tog = ~b_tog; bv = b_tog; end
            default: begin av = 1'($urandom_range(0, 1)); bv = 1'($urandom_range(0, 1)); end
        endcase
        bus.a_valid = av;
        bus.b_valid = bv;
        bus.a_data  = a_base + DW'(a_idx);
        bus.b_data  = b_base + DW'(b_idx);

        #4;
        check("a_rdy_wo_bvalid", bus.a_ready & ~bus.b_valid, 0);
        check("b_rdy_wo_avalid", bus.b_ready & ~bus.a_valid, 0);
        if (bus.a_valid && bus.b_valid) check("rdy_sym", bus.a_ready, bus.b_ready);
        if (frozen || !active) check("rdy_blocked", {bus.a_ready, bus.b_ready}, 0);
        xfer = bus.a_valid && bus.a_ready && bus.b_valid && bus.b_ready;
        if (xfer) begin
            exp_a.push_back(bus.a_data);
            exp_b.push_back(bus.b_data);
            a_idx++; b_idx++;
            xfer_in_frame++;
            if (xfer_in_frame == R) begin
                xfer_in_frame = 0;
                frozen = 1;
            end
        end
        if (done_fell) frozen = 0;
    endtask

    task automatic run_session(input int n, input int md, input int shortf, input bit exp_err,
                               input logic [DW-1:0] ab, input logic [DW-1:0] bb);
        int p0, w0, cyc;
        model_clear();
        mode = md; short_frame = shortf; a_base = ab; b_base = bb;
        p0 = sess_pulses; w0 = writes_seen;
        nframes = FW'(n);
        start   = 1'b1;
        active  = 1;
        step();
        start = 1'b0;
        check("err_clr_on_start", err, 0);
        cyc = 0;
        while (sess_pulses == p0 && cyc < 200*n + 200) begin
            step();
            cyc++;
        end
        check("sess_seen", sess_pulses - p0, 1);
        check("frame_cnt", frame_cnt, n);
        check("err", err, exp_err);
        check("writes", writes_seen - w0, n*R);
        check("pending", exp_a.size(), 0);
        repeat (3) step();
        check("one_pulse", sess_pulses - p0, 1);
        check("frame_hold", frame_cnt, n);
        check("err_hold", err, exp_err);
    endtask

    initial begin
        int w0, cyc;
        logic [DW-1:0] exp_emit[4];
        bus.a_valid = 0; bus.b_valid = 0; bus.a_data = '0; bus.b_data = '0;
        bus.al_dv = 0; bus.al_done = 0;
        hang = 0; mode = 0; b_tog = 0; a_base = '0; b_base = '0;
        model_clear();

        #1 rst = 1'b1;
        #2;
        check("rst_busy", busy, 0);
        check("rst_write", bus.write, 0);
        check("rst_x", {bus.x_i1, bus.x_i2}, 0);
        check("rst_frame", frame_cnt, 0);
        check("rst_flags", {sess_done, err, bus.a_ready, bus.b_ready}, 0);
        repeat (2) step();
        rst = 1'b0;
        step();

        // Basic single frame with fixed data and emitted-order check
        run_session(1, 0, -1, 0, 32'h11, 32'h21);
        exp_emit[0] = 32'h11; exp_emit[1] = 32'h12; exp_emit[2] = 32'h21; exp_emit[3] = 32'h22;
        check("emit_len", emitted.size(), 4);
        for (int i = 0; i < 4; i++) check("emit", emitted[i], exp_emit[i]);

        // B toggling, A always valid
        run_session(2, 1, -1, 0, 32'h100, 32'h200);
        // Both valids held high across WAIT/DRAIN
        run_session(2, 0, -1, 0, 32'h300, 32'h400);
        // Short burst on first frame, err must stick, next start clears it
        run_session(3, 2, 0, 1, 32'h500, 32'h600);
        run_session(1, 2, -1, 0, 32'h700, 32'h800);

        for (int i = 0; i < 5; i++)
            run_session(int'($urandom_range(1, 4)), 2, -1, 0, $urandom, $urandom);

        // Reset in the middle of a frame after the first pair
        model_clear();
        mode = 0; a_base = 32'hA0; b_base = 32'hB0; short_frame = -1;
        w0 = writes_seen;
        nframes = 16'd2; start = 1'b1; active = 1;
        step();
        start = 1'b0;
        cyc = 0;
        while (writes_seen == w0 && cyc < 50) begin step(); cyc++; end
        check("pre_rst_write", writes_seen - w0, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_write", bus.write, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_x", {bus.x_i1, bus.x_i2}, 0);
        check("mid_rst_rdy", {bus.a_ready, bus.b_ready}, 0);
        check("mid_rst_misc", {frame_cnt, sess_done, err}, 0);
        model_clear();
        repeat (2) step();
        rst = 1'b0;
        nframes = '0; start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        check("zero_start_busy", busy, 0);
        check("zero_start_frame", frame_cnt, 0);

`ifdef ALIGN_CTRL_TIMEOUT_EN
        // Aligner never raises done: watchdog must end the session
        model_clear();
        hang = 1; mode = 0; a_base = 32'hC0; b_base = 32'hD0;
        w0 = sess_pulses;
        nframes = 16'd1; start = 1'b1; active = 1;
        step();
        start = 1'b0;
        cyc = 0;
        while (sess_pulses == w0 && cyc < 70000) begin step(); cyc++; end
        check("wd_sess", sess_pulses - w0, 1);
        check("wd_err", err, 1);
        check("wd_busy", busy, 0);
        check("wd_frame", frame_cnt, 0);
        hang = 0;
        model_clear();
        step();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
